conv_sched: RTL

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_sched_if.sv | 36 +++
 rtl/conv_sched.sv | 135 +++++++++++++
 2 files changed

// File: rtl/conv_sched_if.sv
// Signal bundle between the round-robin converter scheduler and its
// environment (shared converter front end plus the sample consumer).
//
// Handshakes (both are level-sensitive and checked on posedge clock):
//   converter: soc=1 requests a conversion; the converter acknowledges by
//              dropping eoc to 0, and signals completion by raising eoc back
//              to 1 with in_data valid.
//   consumer:  dav_=0 offers out_data/out_ch; the consumer accepts by pulling
//              rfd to 0, and the offer is closed once rfd returns to 1.
interface conv_sched_if #(
  parameter int N = 8
);
  logic [3:0]   en;
  logic [1:0]   sel;
  logic         soc;
  logic         eoc;
  logic [N-1:0] in_data;
  logic         dav_;
  logic         rfd;
  logic [N-1:0] out_data;
  logic [1:0]   out_ch;
  logic         busy;
  logic [2:0]   dbg_state;

  // Scheduler side
  modport master (
    input  en, eoc, in_data, rfd,
    output sel, soc, dav_, out_data, out_ch, busy, dbg_state
  );

  // Converter/consumer/environment side
  modport slave (
    output en, eoc, in_data, rfd,
    input  sel, soc, dav_, out_data, out_ch, busy, dbg_state
  );
endinterface

// File: rtl/conv_sched.sv
// Shares one converter among four analog channels. Enabled channels are
// served round-robin; each conversion waits SETTLE cycles after the mux is
// switched, then runs a soc/eoc exchange, and the result is handed to the
// consumer over dav_/rfd before the next channel is scheduled.
module conv_sched #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic        clock,
  input  logic        reset_,
  conv_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_START   = 3'd2,
    S_CONV    = 3'd3,
    S_OFFER   = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [1:0]    out_ch_q, out_ch_d;

  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          found;

  // Next channel after LAST in cyclic order; the loop runs from the farthest
  // candidate to the nearest so the nearest enabled channel wins.
  always_comb begin
    pick  = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (bus.en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // State and datapath registers; reset leaves LAST at 3 so channel 0 is
  // the first candidate.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
    end
  end

  // Next-state logic; en is only looked at in IDLE so a conversion in
  // flight is never redirected.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d   = pick;
          cnt_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (!bus.eoc) begin
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (bus.eoc) begin
          out_data_d = bus.in_data;
          out_ch_d   = sel_q;
          last_d     = sel_q;
          state_d    = S_OFFER;
        end
      end
      S_OFFER: begin
        if (!bus.rfd) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (bus.rfd) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state so reset clears soc/dav_ at once.
  always_comb begin
    bus.soc       = (state_q == S_START);
    bus.dav_      = (state_q != S_OFFER);
    bus.busy      = (state_q != S_IDLE);
    bus.sel       = sel_q;
    bus.out_data  = out_data_q;
    bus.out_ch    = out_ch_q;
    bus.dbg_state = state_q;
  end

endmodule
